// File: rtl/pixelbox_pkg.sv
// Shared definitions for the DVP pixel capture path: FSM encoding, RGB565 field
// positions and default frame geometry.
package pixelbox_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_WAIT_VS = 2'd2,
        ST_RUN     = 2'd3
    } cap_state_t;

    localparam int R5_MSB = 15;
    localparam int R5_LSB = 11;
    localparam int G6_MSB = 10;
    localparam int G6_LSB = 5;
    localparam int B5_MSB = 4;
    localparam int B5_LSB = 0;

    localparam int DEFAULT_H_ACT = 640;
    localparam int DEFAULT_V_ACT = 480;

endpackage

// File: rtl/rgb565_to_rgb888.sv
// Combinational RGB565 -> RGB888 expansion; low bits are filled by replicating
// each channel's MSBs so full-scale inputs map to 0xFF.
module rgb565_to_rgb888
    import pixelbox_pkg::*;
(
    input  logic [15:0] pix565,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue
);

    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;

    assign r5 = pix565[R5_MSB:R5_LSB];
    assign g6 = pix565[G6_MSB:G6_LSB];
    assign b5 = pix565[B5_MSB:B5_LSB];

    assign red   = {r5, r5[4:2]};
    assign green = {g6, g6[5:4]};
    assign blue  = {b5, b5[4:2]};

endmodule

// File: rtl/dvp_rgb565_capture.sv
// DVP byte-stream capture: drops start-up frames, pairs RGB565 bytes into RGB888
// pixels and flags lines/frames whose geometry is off.
module dvp_rgb565_capture
    import pixelbox_pkg::*;
#(
    parameter int H_ACT       = DEFAULT_H_ACT,
    parameter int V_ACT       = DEFAULT_V_ACT,
    parameter int SKIP_FRAMES = 10,
    parameter bit VS_POL      = 1'b1
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       cfg_done,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [7:0] cam_data,
    output logic [7:0] tx_data_R,
    output logic [7:0] tx_data_G,
    output logic [7:0] tx_data_B,
    output logic       po_flag,
    output logic       o_vs,
    output logic       line_err,
    output logic       frame_err
);

    localparam int XW = $clog2(H_ACT + 2);
    localparam int YW = $clog2(V_ACT + 2);
    localparam int SW = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES + 1) : 1;

    localparam logic [XW-1:0] X_TARGET = XW'(H_ACT);
    localparam logic [YW-1:0] Y_TARGET = YW'(V_ACT);
    localparam logic [XW-1:0] X_MAX    = '1;
    localparam logic [YW-1:0] Y_MAX    = '1;

    cap_state_t    state, state_next;
    logic [SW-1:0] skip_cnt, skip_next;

    logic          vs_r, vs_d, href_r, href_d;
    logic [7:0]    data_r;
    logic          fs, le;
    logic          run_now, run_next;

    logic          phase;
    logic [7:0]    hi_byte;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          line_void;
    logic [7:0]    red, green, blue;

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            vs_r   <= 1'b0;
            vs_d   <= 1'b0;
            href_r <= 1'b0;
            href_d <= 1'b0;
            data_r <= 8'h00;
        end else begin
            vs_r   <= (cam_vsync == VS_POL);
            vs_d   <= vs_r;
            href_r <= cam_href;
            href_d <= href_r;
            data_r <= cam_data;
        end
    end

    assign fs = vs_r & ~vs_d;
    assign le = href_d & ~href_r;

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_next;
            skip_cnt <= skip_next;
        end
    end

    always_comb begin
        state_next = state;
        skip_next  = skip_cnt;
        case (state)
            ST_IDLE: begin
                if (cfg_done) begin
                    skip_next  = '0;
                    state_next = (SKIP_FRAMES == 0) ? ST_WAIT_VS : ST_SKIP;
                end
            end
            ST_SKIP: begin
                if (fs) begin
                    skip_next = skip_cnt + SW'(1);
                    if (skip_cnt == SW'(SKIP_FRAMES - 1)) begin
                        state_next = ST_WAIT_VS;
                    end
                end
            end
            ST_WAIT_VS: begin
                if (fs) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (!cfg_done) begin
            state_next = ST_IDLE;
        end
    end

    // o_vs looks at the next state so the first captured frame's vsync is not clipped.
    assign run_now  = (state == ST_RUN) && cfg_done;
    assign run_next = (state_next == ST_RUN);

    rgb565_to_rgb888 u_expand (
        .pix565 ({hi_byte, data_r}),
        .red    (red),
        .green  (green),
        .blue   (blue)
    );

    // A line cut by a frame start is marked void so its tail neither emits pixels nor errors.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            phase     <= 1'b0;
            hi_byte   <= 8'h00;
            x_cnt     <= '0;
            y_cnt     <= '0;
            line_void <= 1'b0;
            tx_data_R <= 8'h00;
            tx_data_G <= 8'h00;
            tx_data_B <= 8'h00;
            po_flag   <= 1'b0;
            o_vs      <= 1'b0;
            line_err  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            po_flag   <= 1'b0;
            line_err  <= 1'b0;
            frame_err <= 1'b0;
            o_vs      <= run_next & vs_r;
            if (!run_now) begin
                phase     <= 1'b0;
                x_cnt     <= '0;
                y_cnt     <= '0;
                line_void <= 1'b0;
            end else if (fs) begin
                frame_err <= (y_cnt != Y_TARGET);
                phase     <= 1'b0;
                x_cnt     <= '0;
                y_cnt     <= '0;
                line_void <= href_r;
            end else if (le) begin
                if (!line_void) begin
                    line_err <= (x_cnt != X_TARGET);
                    if (y_cnt != Y_MAX) begin
                        y_cnt <= y_cnt + YW'(1);
                    end
                end
                line_void <= 1'b0;
                phase     <= 1'b0;
                x_cnt     <= '0;
            end else if (href_r && !line_void) begin
                phase <= ~phase;
                if (!phase) begin
                    hi_byte <= data_r;
                end else begin
                    tx_data_R <= red;
                    tx_data_G <= green;
                    tx_data_B <= blue;
                    po_flag   <= 1'b1;
                    if (x_cnt != X_MAX) begin
                        x_cnt <= x_cnt + XW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dvp_rgb565_capture.sv
// Randomised bench for dvp_rgb565_capture: a frame-level model predicts pixels,
// their arrival cycles, geometry errors and the delayed vsync of two DUT polarities.
module tb_dvp_rgb565_capture;

    localparam int H      = 8;
    localparam int V      = 4;
    localparam int SKIP   = 2;
    localparam int VS_LEN = 3;

    logic       clk = 1'b0;
    logic       rst_n, cfg_done, vsync, href;
    logic [7:0] data;
    logic [7:0] r_p, g_p, b_p, r_n, g_n, b_n;
    logic       po_p, ovs_p, le_p, fe_p, po_n, ovs_n, le_n, fe_n;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dvp_rgb565_capture #(.H_ACT(H), .V_ACT(V), .SKIP_FRAMES(SKIP), .VS_POL(1'b1)) dut (
        .sclk(clk), .rst_n(rst_n), .cfg_done(cfg_done), .cam_vsync(vsync),
        .cam_href(href), .cam_data(data),
        .tx_data_R(r_p), .tx_data_G(g_p), .tx_data_B(b_p),
        .po_flag(po_p), .o_vs(ovs_p), .line_err(le_p), .frame_err(fe_p)
    );

    dvp_rgb565_capture #(.H_ACT(H), .V_ACT(V), .SKIP_FRAMES(SKIP), .VS_POL(1'b0)) dut_n (
        .sclk(clk), .rst_n(rst_n), .cfg_done(cfg_done), .cam_vsync(~vsync),
        .cam_href(href), .cam_data(data),
        .tx_data_R(r_n), .tx_data_G(g_n), .tx_data_B(b_n),
        .po_flag(po_n), .o_vs(ovs_n), .line_err(le_n), .frame_err(fe_n)
    );

    // Observed activity, logged away from the active edge.
    logic [23:0] got_rgb[$];
    logic [23:0] got_rgb_n[$];
    int          got_cyc[$];
    int          rise_p[$], fall_p[$], rise_n[$], fall_n[$];
    int          line_errs = 0, frame_errs = 0, line_errs_n = 0, frame_errs_n = 0;
    logic        ovs_p_d = 1'b0, ovs_n_d = 1'b0;

    always @(negedge clk) begin
        if (po_p === 1'b1) begin
            got_rgb.push_back({r_p, g_p, b_p});
            got_cyc.push_back(cyc);
        end
        if (po_n === 1'b1) got_rgb_n.push_back({r_n, g_n, b_n});
        if (le_p === 1'b1) line_errs++;
        if (fe_p === 1'b1) frame_errs++;
        if (le_n === 1'b1) line_errs_n++;
        if (fe_n === 1'b1) frame_errs_n++;
        if (ovs_p === 1'b1 && ovs_p_d !== 1'b1) rise_p.push_back(cyc);
        if (ovs_p !== 1'b1 && ovs_p_d === 1'b1) fall_p.push_back(cyc);
        if (ovs_n === 1'b1 && ovs_n_d !== 1'b1) rise_n.push_back(cyc);
        if (ovs_n !== 1'b1 && ovs_n_d === 1'b1) fall_n.push_back(cyc);
        ovs_p_d = ovs_p;
        ovs_n_d = ovs_n;
    end

    // Frame-level reference model.
    logic [23:0] exp_rgb[$];
    int          exp_cyc[$];
    int          exp_rise[$], exp_fall[$];
    int          exp_line_errs = 0, exp_frame_errs = 0;
    bit          model_active = 1'b0;
    int          fs_seen = 0;
    int          lines_in_frame = 0;
    logic [7:0]  lb[$];

    function automatic logic [23:0] expand(input logic [15:0] p);
        int r, g, b;
        r = int'(p) / 2048;
        g = (int'(p) / 32) % 64;
        b = int'(p) % 32;
        return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            href = 1'b0;
            data = 8'($urandom);
        end
    endtask

    task automatic clear_logs();
        got_rgb.delete(); got_rgb_n.delete(); got_cyc.delete();
        rise_p.delete(); fall_p.delete(); rise_n.delete(); fall_n.delete();
        exp_rgb.delete(); exp_cyc.delete(); exp_rise.delete(); exp_fall.delete();
        line_errs = 0; frame_errs = 0; line_errs_n = 0; frame_errs_n = 0;
        exp_line_errs = 0; exp_frame_errs = 0;
    endtask

    task automatic assert_cfg();
        tick();
        cfg_done = 1'b1;
        model_active = 1'b1;
        fs_seen = 0;
        idle(3);
    endtask

    task automatic fill_random(input int n);
        lb.delete();
        repeat (n) lb.push_back(8'($urandom));
    endtask

    task automatic begin_frame();
        tick();
        vsync = 1'b1;
        href  = 1'b0;
        if (model_active) begin
            if (fs_seen > SKIP && lines_in_frame != V) exp_frame_errs++;
            fs_seen++;
            if (fs_seen > SKIP) begin
                exp_rise.push_back(cyc + 2);
                exp_fall.push_back(cyc + VS_LEN + 2);
            end
        end
        lines_in_frame = 0;
        repeat (VS_LEN - 1) tick();
        tick();
        vsync = 1'b0;
        tick();
    endtask

    // abort_at < 0: plain line; kind 1 drops cfg_done, kind 2 pulses rst_n for two cycles.
    task automatic send_line(input int abort_at, input int kind);
        bit live;
        live = model_active && (fs_seen > SKIP);
        for (int i = 0; i < lb.size(); i++) begin
            tick();
            href = 1'b1;
            data = lb[i];
            if (live && (i % 2 == 1) && (abort_at < 0 || i < abort_at - 1)) begin
                exp_rgb.push_back(expand({lb[i-1], lb[i]}));
                exp_cyc.push_back(cyc + 2);
            end
            if (i == abort_at) begin
                if (kind == 1) cfg_done = 1'b0;
                else rst_n = 1'b0;
                live = 1'b0;
                model_active = 1'b0;
            end
            if (kind == 2 && i == abort_at + 2) rst_n = 1'b1;
        end
        if (live) begin
            lines_in_frame++;
            if (lb.size() / 2 != H) exp_line_errs++;
        end
        idle(3);
    endtask

    task automatic send_frame(input int nlines);
        begin_frame();
        repeat (nlines) begin
            fill_random(2 * H);
            send_line(-1, 0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (8) begin
            tick();
            cfg_done = 1'($urandom);
            vsync    = 1'($urandom);
            href     = 1'($urandom);
            data     = 8'($urandom);
            @(negedge clk);
            checks++;
            if ({r_p, g_p, b_p, po_p, ovs_p, le_p, fe_p} !== 28'd0 ||
                {r_n, g_n, b_n, po_n, ovs_n, le_n, fe_n} !== 28'd0) begin
                failures++;
                $display("[TB] FAIL reset_outputs got=%h/%h exp=0",
                         {r_p, g_p, b_p, po_p, ovs_p, le_p, fe_p},
                         {r_n, g_n, b_n, po_n, ovs_n, le_n, fe_n});
            end
        end
        tick();
        rst_n = 1'b1; cfg_done = 1'b0; vsync = 1'b0; href = 1'b0;
        idle(4);
        clear_logs();
    endtask

    task automatic test_skip();
        clear_logs();
        assert_cfg();
        repeat (4) send_frame(V);
        idle(5);
        checks++;
        if (got_rgb.size() != 2 * V * H || got_rgb.size() != exp_rgb.size()) begin
            failures++;
            $display("[TB] FAIL skip_pixel_count got=%0d exp=%0d", got_rgb.size(), exp_rgb.size());
        end
        for (int i = 0; i < exp_rgb.size() && i < got_rgb.size(); i++) begin
            checks++;
            if (got_rgb[i] !== exp_rgb[i] || got_cyc[i] != exp_cyc[i]) begin
                failures++;
                $display("[TB] FAIL skip_pixel[%0d] got=%h@%0d exp=%h@%0d",
                         i, got_rgb[i], got_cyc[i], exp_rgb[i], exp_cyc[i]);
            end
        end
        checks++;
        if (line_errs != 0 || frame_errs != exp_frame_errs) begin
            failures++;
            $display("[TB] FAIL skip_errors got=%0d/%0d exp=0/%0d", line_errs, frame_errs, exp_frame_errs);
        end
        checks++;
        if (rise_p.size() != exp_rise.size() || (rise_p.size() > 0 && rise_p[0] != exp_rise[0])) begin
            failures++;
            $display("[TB] FAIL skip_ovs_rise got=%0d exp=%0d", rise_p.size(), exp_rise.size());
        end
    endtask

    task automatic test_pixel_path();
        logic [23:0] want[3];
        want[0] = 24'hFF0000; want[1] = 24'h00FF00; want[2] = 24'h0000FF;
        clear_logs();
        begin_frame();
        fill_random(2 * H - 6);
        lb.push_front(8'h1F); lb.push_front(8'h00);
        lb.push_front(8'hE0); lb.push_front(8'h07);
        lb.push_front(8'h00); lb.push_front(8'hF8);
        send_line(-1, 0);
        repeat (V - 1) begin
            fill_random(2 * H);
            send_line(-1, 0);
        end
        idle(5);
        checks++;
        if (got_rgb.size() != exp_rgb.size()) begin
            failures++;
            $display("[TB] FAIL path_pixel_count got=%0d exp=%0d", got_rgb.size(), exp_rgb.size());
        end
        for (int i = 0; i < 3 && i < got_rgb.size(); i++) begin
            checks++;
            if (got_rgb[i] !== want[i]) begin
                failures++;
                $display("[TB] FAIL path_primary[%0d] got=%h exp=%h", i, got_rgb[i], want[i]);
            end
        end
        for (int i = 0; i < exp_rgb.size() && i < got_rgb.size(); i++) begin
            checks++;
            if (got_rgb[i] !== exp_rgb[i] || got_cyc[i] != exp_cyc[i]) begin
                failures++;
                $display("[TB] FAIL path_pixel[%0d] got=%h@%0d exp=%h@%0d",
                         i, got_rgb[i], got_cyc[i], exp_rgb[i], exp_cyc[i]);
            end
        end
    endtask

    task automatic test_geometry();
        clear_logs();
        begin_frame();
        fill_random(2 * H - 2);
        send_line(-1, 0);
        repeat (V - 1) begin
            fill_random(2 * H);
            send_line(-1, 0);
        end
        send_frame(V - 1);
        send_frame(V);
        send_frame(V);
        idle(5);
        checks++;
        if (line_errs != 1 || line_errs != exp_line_errs) begin
            failures++;
            $display("[TB] FAIL geom_line_err got=%0d exp=%0d", line_errs, exp_line_errs);
        end
        checks++;
        if (frame_errs != 1 || frame_errs != exp_frame_errs) begin
            failures++;
            $display("[TB] FAIL geom_frame_err got=%0d exp=%0d", frame_errs, exp_frame_errs);
        end
        checks++;
        if (got_rgb.size() != exp_rgb.size()) begin
            failures++;
            $display("[TB] FAIL geom_pixel_count got=%0d exp=%0d", got_rgb.size(), exp_rgb.size());
        end
    endtask

    task automatic test_odd_bytes();
        clear_logs();
        begin_frame();
        fill_random(2 * H + 1);
        send_line(-1, 0);
        repeat (V - 1) begin
            fill_random(2 * H);
            send_line(-1, 0);
        end
        send_frame(V);
        idle(5);
        checks++;
        if (got_rgb.size() != exp_rgb.size() || got_rgb.size() != 2 * V * H) begin
            failures++;
            $display("[TB] FAIL odd_pixel_count got=%0d exp=%0d", got_rgb.size(), exp_rgb.size());
        end
        for (int i = 0; i < exp_rgb.size() && i < got_rgb.size(); i++) begin
            checks++;
            if (got_rgb[i] !== exp_rgb[i] || got_cyc[i] != exp_cyc[i]) begin
                failures++;
                $display("[TB] FAIL odd_pixel[%0d] got=%h@%0d exp=%h@%0d",
                         i, got_rgb[i], got_cyc[i], exp_rgb[i], exp_cyc[i]);
            end
        end
        checks++;
        if (line_errs != 0 || frame_errs != 0) begin
            failures++;
            $display("[TB] FAIL odd_errors got=%0d/%0d exp=0/0", line_errs, frame_errs);
        end
    endtask

    task automatic test_vs_pol();
        clear_logs();
        send_frame(V);
        send_frame(V);
        idle(5);
        checks++;
        if (rise_n.size() != exp_rise.size() || fall_n.size() != exp_fall.size() ||
            rise_p.size() != exp_rise.size()) begin
            failures++;
            $display("[TB] FAIL vspol_edge_count got=%0d/%0d/%0d exp=%0d",
                     rise_n.size(), fall_n.size(), rise_p.size(), exp_rise.size());
        end
        for (int i = 0; i < exp_rise.size() && i < rise_n.size() && i < fall_n.size() && i < rise_p.size(); i++) begin
            checks++;
            if (rise_n[i] != exp_rise[i] || fall_n[i] != exp_fall[i] || rise_p[i] != exp_rise[i]) begin
                failures++;
                $display("[TB] FAIL vspol_ovs[%0d] got=%0d-%0d/%0d exp=%0d-%0d",
                         i, rise_n[i], fall_n[i], rise_p[i], exp_rise[i], exp_fall[i]);
            end
        end
        checks++;
        if (got_rgb_n.size() != exp_rgb.size() || line_errs_n != 0 || frame_errs_n != 0) begin
            failures++;
            $display("[TB] FAIL vspol_stream got=%0d/%0d/%0d exp=%0d/0/0",
                     got_rgb_n.size(), line_errs_n, frame_errs_n, exp_rgb.size());
        end
        for (int i = 0; i < exp_rgb.size() && i < got_rgb_n.size(); i++) begin
            checks++;
            if (got_rgb_n[i] !== exp_rgb[i]) begin
                failures++;
                $display("[TB] FAIL vspol_pixel[%0d] got=%h exp=%h", i, got_rgb_n[i], exp_rgb[i]);
            end
        end
    endtask

    task automatic test_abort();
        clear_logs();
        begin_frame();
        fill_random(2 * H);
        send_line(6, 1);
        idle(4);
        checks++;
        if (got_rgb.size() != 2 || got_rgb.size() != exp_rgb.size() || line_errs != 0 || frame_errs != 0) begin
            failures++;
            $display("[TB] FAIL abort_cfg got=%0d/%0d/%0d exp=%0d/0/0",
                     got_rgb.size(), line_errs, frame_errs, exp_rgb.size());
        end
        assert_cfg();
        repeat (SKIP + 1) send_frame(V);
        begin_frame();
        fill_random(2 * H);
        send_line(8, 2);
        model_active = 1'b1;
        fs_seen = 0;
        idle(3);
        repeat (SKIP + 1) send_frame(V);
        idle(5);
        checks++;
        if (got_rgb.size() != exp_rgb.size()) begin
            failures++;
            $display("[TB] FAIL abort_pixel_count got=%0d exp=%0d", got_rgb.size(), exp_rgb.size());
        end
        for (int i = 0; i < exp_rgb.size() && i < got_rgb.size(); i++) begin
            checks++;
            if (got_rgb[i] !== exp_rgb[i] || got_cyc[i] != exp_cyc[i]) begin
                failures++;
                $display("[TB] FAIL abort_pixel[%0d] got=%h@%0d exp=%h@%0d",
                         i, got_rgb[i], got_cyc[i], exp_rgb[i], exp_cyc[i]);
            end
        end
        checks++;
        if (line_errs != 0 || frame_errs != exp_frame_errs || rise_p.size() != exp_rise.size()) begin
            failures++;
            $display("[TB] FAIL abort_side got=%0d/%0d/%0d exp=0/%0d/%0d",
                     line_errs, frame_errs, rise_p.size(), exp_frame_errs, exp_rise.size());
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_done = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00;
        test_reset();
        test_skip();
        test_pixel_path();
        test_geometry();
        test_odd_bytes();
        test_vs_pol();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
